// File: rtl/multiport_register_file_pkg.sv
// Shared defaults for the multi-port register file.
// The top level and the read-port sub-module both take these as parameter defaults.
// That keeps their widths in step when only the top is re-parameterised.
package multiport_register_file_pkg;

    localparam int DEF_N_BIT_DATA    = 16;
    localparam int DEF_N_BIT_ADDRESS = 16;
    localparam int DEF_N_WRITE       = 4;
    localparam int DEF_N_READ        = 16;

endpackage

// File: rtl/multiport_register_file_read_port.sv
// rf_read_port: a single read port of the register file.
// It is a full-width read mux over the cell array, followed by an output register
// with a load enable and an asynchronous clear.
//
// Ports:
//   clock, reset  - rising-edge clock; asynchronous active-high clear of data_out
//   read          - load enable; when low, data_out holds its value
//   address_read  - cell selected for this port
//   cells         - current contents of every cell (pre-write view for this edge)
//   data_out      - registered read data, one cycle after read
module rf_read_port
    import multiport_register_file_pkg::*;
#(
    parameter int N_BIT_DATA    = DEF_N_BIT_DATA,
    parameter int N_BIT_ADDRESS = DEF_N_BIT_ADDRESS
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     read,
    input  logic [N_BIT_ADDRESS-1:0] address_read,
    input  logic [N_BIT_DATA-1:0]    cells [2**N_BIT_ADDRESS],
    output logic [N_BIT_DATA-1:0]    data_out
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_out <= '0;
        end else if (read) begin
            data_out <= cells[address_read];
        end
    end

endmodule

// File: rtl/multiport_register_file.sv
// multiport_register_file: 2**N_BIT_ADDRESS cells of N_BIT_DATA bits.
// The array has N_WRITE synchronous write ports and N_READ registered read ports.
//
// Ports:
//   clock          - single clock; all state changes occur on its rising edge
//   reset          - asynchronous active-high; clears every cell and every data_out
//   write[i]       - write enable for write port i
//   address_write  - write address, one per write port
//   data_in        - write data, one per write port
//   read[k]        - read enable for read port k (data_out[k] holds when low)
//   address_read   - read address, one per read port
//   data_out       - registered read data, one per read port, one-cycle latency
//
// Several write ports may target the same cell in one cycle. In that case the
// highest-index port wins, and no error is raised. Reads sample the cell array
// as it was before the edge's writes, so a read of a cell being written returns
// its old content.
module multiport_register_file
    import multiport_register_file_pkg::*;
#(
    parameter int N_BIT_DATA    = DEF_N_BIT_DATA,
    parameter int N_BIT_ADDRESS = DEF_N_BIT_ADDRESS,
    parameter int N_WRITE       = DEF_N_WRITE,
    parameter int N_READ        = DEF_N_READ
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     write         [N_WRITE],
    input  logic [N_BIT_ADDRESS-1:0] address_write [N_WRITE],
    input  logic [N_BIT_DATA-1:0]    data_in       [N_WRITE],
    input  logic                     read          [N_READ],
    input  logic [N_BIT_ADDRESS-1:0] address_read  [N_READ],
    output logic [N_BIT_DATA-1:0]    data_out      [N_READ]
);

    localparam int N_CELLS = 2**N_BIT_ADDRESS;

    logic [N_BIT_DATA-1:0] cells [N_CELLS];

    // Each cell scans the write ports in ascending order.
    // A later matching port overrides an earlier one, so the highest index wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CELLS; c++) begin
                cells[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CELLS; c++) begin
                for (int w = 0; w < N_WRITE; w++) begin
                    if (write[w] && (address_write[w] == N_BIT_ADDRESS'(c))) begin
                        cells[c] <= data_in[w];
                    end
                end
            end
        end
    end

    // Each read port sees the registered cell array. Its output register therefore
    // captures the pre-write contents on the same edge.
    for (genvar k = 0; k < N_READ; k++) begin : g_read
        rf_read_port #(
            .N_BIT_DATA   (N_BIT_DATA),
            .N_BIT_ADDRESS(N_BIT_ADDRESS)
        ) u_read_port (
            .clock       (clock),
            .reset       (reset),
            .read        (read[k]),
            .address_read(address_read[k]),
            .cells       (cells),
            .data_out    (data_out[k])
        );
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench for multiport_register_file.
// It uses a small address space (64 cells) so that full-array marches stay short.
module tb_multiport_register_file;

    localparam int DW = 16;
    localparam int AW = 6;
    localparam int NW = 4;
    localparam int NR = 16;
    localparam int NC = 2**AW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          write         [NW];
    logic [AW-1:0] address_write [NW];
    logic [DW-1:0] data_in       [NW];
    logic          read          [NR];
    logic [AW-1:0] address_read  [NR];
    logic [DW-1:0] data_out      [NR];

    int n_cmp  = 0;
    int n_fail = 0;

    multiport_register_file #(
        .N_BIT_DATA(DW), .N_BIT_ADDRESS(AW), .N_WRITE(NW), .N_READ(NR)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .write        (write),
        .address_write(address_write),
        .data_in      (data_in),
        .read         (read),
        .address_read (address_read),
        .data_out     (data_out)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [NW-1:0]         we;
        logic [NW-1:0][AW-1:0] wa;
        logic [NW-1:0][DW-1:0] wd;
        logic [3:0]            rport;
        logic [AW-1:0]         ra;
        logic [DW-1:0]         expv;
    } vec_t;

    vec_t vt [12];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    task automatic idle();
        for (int i = 0; i < NW; i++) begin
            write[i] = 1'b0; address_write[i] = '0; data_in[i] = '0;
        end
        for (int k = 0; k < NR; k++) begin
            read[k] = 1'b0; address_read[k] = '0;
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic vec_t mkv(input logic [NW-1:0] we,
                                 input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                 input logic [AW-1:0] a2, input logic [DW-1:0] d2,
                                 input logic [AW-1:0] a3, input logic [DW-1:0] d3,
                                 input logic [3:0] rp, input logic [AW-1:0] ra,
                                 input logic [DW-1:0] e);
        vec_t v;
        v.we = we;
        v.wa[0] = a0; v.wd[0] = d0;
        v.wa[1] = a1; v.wd[1] = d1;
        v.wa[2] = a2; v.wd[2] = d2;
        v.wa[3] = a3; v.wd[3] = d3;
        v.rport = rp; v.ra = ra; v.expv = e;
        return v;
    endfunction

    initial begin
        idle();

        // 1. reset state
        repeat (2) @(posedge clock);
        #1;
        for (int k = 0; k < NR; k++) chk($sformatf("reset_out[%0d]", k), data_out[k], '0);
        @(negedge clock);
        reset = 1'b0;
        read[0] = 1'b1; address_read[0] = 6'd0;
        read[1] = 1'b1; address_read[1] = 6'd1;
        read[2] = 1'b1; address_read[2] = 6'(NC-1);
        step();
        chk("post_reset_rd0",  data_out[0], '0);
        chk("post_reset_rd1",  data_out[1], '0);
        chk("post_reset_rdmx", data_out[2], '0);
        idle();

        // 2. parallel fill: data = address, port = address mod NW
        for (int c = 0; c < NC / NW; c++) begin
            for (int j = 0; j < NW; j++) begin
                write[j] = 1'b1;
                address_write[j] = AW'(c * NW + j);
                data_in[j] = DW'(c * NW + j);
            end
            step();
        end
        idle();
        for (int r = 0; r < 20; r++) begin
            logic [AW-1:0] ra [NR];
            for (int k = 0; k < NR; k++) begin
                ra[k] = AW'($urandom_range(0, NC - 1));
                read[k] = 1'b1; address_read[k] = ra[k];
            end
            step();
            for (int k = 0; k < NR; k++)
                chk($sformatf("fill_rd p%0d a%0d", k, ra[k]), data_out[k], DW'(ra[k]));
        end
        idle();

        // 3. MATS+ march, single random port per access
        for (int a = 0; a < NC; a++) begin
            int p;
            p = $urandom_range(0, NW - 1);
            write[p] = 1'b1; address_write[p] = AW'(a); data_in[p] = 16'hFFFF;
            step();
            write[p] = 1'b0;
        end
        for (int a = NC - 1; a >= 0; a--) begin
            int k;
            k = $urandom_range(0, NR - 1);
            read[k] = 1'b1; address_read[k] = AW'(a);
            step();
            chk($sformatf("march1 a%0d p%0d", a, k), data_out[k], 16'hFFFF);
            read[k] = 1'b0;
        end
        for (int a = NC - 1; a >= 0; a--) begin
            int p;
            p = $urandom_range(0, NW - 1);
            write[p] = 1'b1; address_write[p] = AW'(a); data_in[p] = 16'h0000;
            step();
            write[p] = 1'b0;
        end
        for (int a = 0; a < NC; a++) begin
            int k;
            k = $urandom_range(0, NR - 1);
            read[k] = 1'b1; address_read[k] = AW'(a);
            step();
            chk($sformatf("march0 a%0d p%0d", a, k), data_out[k], 16'h0000);
            read[k] = 1'b0;
        end
        idle();

        // 4/5. Directed vectors: conflicts and read-during-write. All cells are 0 at this point.
        vt[0]  = mkv(4'b1001, 6'h10, 16'h1111, 6'h0, 16'h0, 6'h0, 16'h0, 6'h10, 16'h3333, 4'd1, 6'h10, 16'h0000);
        vt[1]  = mkv(4'b0000, 6'h0, 16'h0, 6'h0, 16'h0, 6'h0, 16'h0, 6'h0, 16'h0, 4'd1, 6'h10, 16'h3333);
        vt[2]  = mkv(4'b0010, 6'h0, 16'h0, 6'h20, 16'h00AA, 6'h0, 16'h0, 6'h0, 16'h0, 4'd5, 6'h20, 16'h0000);
        vt[3]  = mkv(4'b0001, 6'h20, 16'h00BB, 6'h0, 16'h0, 6'h0, 16'h0, 6'h0, 16'h0, 4'd5, 6'h20, 16'h00AA);
        vt[4]  = mkv(4'b0000, 6'h0, 16'h0, 6'h0, 16'h0, 6'h0, 16'h0, 6'h0, 16'h0, 4'd5, 6'h20, 16'h00BB);
        vt[5]  = mkv(4'b0110, 6'h0, 16'h0, 6'h00, 16'h1234, 6'h3F, 16'hBEEF, 6'h0, 16'h0, 4'd15, 6'h3F, 16'h0000);
        vt[6]  = mkv(4'b0000, 6'h0, 16'h0, 6'h0, 16'h0, 6'h0, 16'h0, 6'h0, 16'h0, 4'd15, 6'h3F, 16'hBEEF);
        vt[7]  = mkv(4'b0000, 6'h0, 16'h0, 6'h0, 16'h0, 6'h0, 16'h0, 6'h0, 16'h0, 4'd0, 6'h00, 16'h1234);
        vt[8]  = mkv(4'b1100, 6'h0, 16'h0, 6'h0, 16'h0, 6'h01, 16'hDEAD, 6'h01, 16'hCAFE, 4'd7, 6'h01, 16'h0000);
        vt[9]  = mkv(4'b0000, 6'h0, 16'h0, 6'h0, 16'h0, 6'h0, 16'h0, 6'h0, 16'h0, 4'd7, 6'h01, 16'hCAFE);
        vt[10] = mkv(4'b0111, 6'h02, 16'h0001, 6'h02, 16'h0002, 6'h02, 16'h0003, 6'h0, 16'h0, 4'd3, 6'h02, 16'h0000);
        vt[11] = mkv(4'b0000, 6'h0, 16'h0, 6'h0, 16'h0, 6'h0, 16'h0, 6'h0, 16'h0, 4'd3, 6'h02, 16'h0003);
        for (int v = 0; v < 12; v++) begin
            idle();
            for (int j = 0; j < NW; j++) begin
                write[j] = vt[v].we[j];
                address_write[j] = vt[v].wa[j];
                data_in[j] = vt[v].wd[j];
            end
            read[vt[v].rport] = 1'b1;
            address_read[vt[v].rport] = vt[v].ra;
            step();
            chk($sformatf("vec%0d", v), data_out[vt[v].rport], vt[v].expv);
        end
        idle();

        // 6. hold while cells change, then a mid-cycle reset
        read[2] = 1'b1; address_read[2] = 6'h10;
        step();
        chk("hold_load", data_out[2], 16'h3333);
        read[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            write[0] = 1'b1; address_write[0] = 6'h10; data_in[0] = DW'(16'h5000 + c);
            address_read[2] = AW'(c);
            step();
            chk($sformatf("hold_cyc%0d", c), data_out[2], 16'h3333);
        end
        idle();
        #2;
        reset = 1'b1;
        #1;
        for (int k = 0; k < NR; k++) chk($sformatf("midreset_out[%0d]", k), data_out[k], '0);
        @(negedge clock);
        reset = 1'b0;
        read[0] = 1'b1; address_read[0] = 6'h10;
        read[1] = 1'b1; address_read[1] = 6'h3F;
        read[2] = 1'b1; address_read[2] = 6'h20;
        step();
        chk("after_reset_0x10", data_out[0], '0);
        chk("after_reset_0x3F", data_out[1], '0);
        chk("after_reset_0x20", data_out[2], '0);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
